// File: rtl/controle_divisao.sv
// rtl/controle_divisao.sv - 4-bit unsigned restoring divider with three-state control FSM
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   rst_n    - synchronous active-low reset
//   start    - division request, sampled only in IDLE
//   A, B     - unsigned dividend / divisor, latched when start is accepted
//   Q, R     - registered quotient / remainder, held until the next result
//   busy     - high in CALC and DONE
//   done     - one-cycle pulse while Q, R and div_zero carry a fresh result
//   div_zero - set when the last completed operation had a zero divisor
module controle_divisao (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic       div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] partRem;   // partial remainder
    logic [3:0] shiftReg;  // dividend bits shift out the top, quotient bits shift in the bottom
    logic [3:0] divisor;
    logic [1:0] stepCnt;

    logic [4:0] shifted;
    logic [5:0] diffFull;
    logic       noBorrow;
    logic [4:0] nextRem;
    logic [3:0] nextShift;
    logic       unusedRemTop;

    // One restoring step. The subtraction is done as an add of the one's
    // complement plus one; a carry out of bit 4 means the divisor fit.
    always_comb begin
        shifted   = {partRem[3:0], shiftReg[3]};
        diffFull  = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + 6'd1;
        noBorrow  = diffFull[5];
        nextRem   = noBorrow ? diffFull[4:0] : shifted;
        nextShift = {shiftReg[2:0], noBorrow};
    end

    // After every step the remainder is below the divisor, so its top bit is
    // always zero and never feeds the next shift.
    assign unusedRemTop = partRem[4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            partRem  <= 5'd0;
            shiftReg <= 4'd0;
            divisor  <= 4'd0;
            stepCnt  <= 2'd0;
            Q        <= 4'd0;
            R        <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        divisor  <= B;
                        partRem  <= 5'd0;
                        shiftReg <= A;
                        stepCnt  <= 2'd3;
                        busy     <= 1'b1;
                        if (B == 4'd0) begin
                            // Zero divisor skips the datapath entirely.
                            Q        <= 4'hF;
                            R        <= A;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    partRem  <= nextRem;
                    shiftReg <= nextShift;
                    stepCnt  <= stepCnt - 2'd1;
                    if (stepCnt == 2'd0) begin
                        Q        <= nextShift;
                        R        <= nextRem[3:0];
                        div_zero <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_divisao.sv
// tb/tb_controle_divisao.sv - directed self-checking bench for controle_divisao
module tb_controle_divisao;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       div_zero;

    int checks = 0;
    int errors = 0;

    controle_divisao dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until done is seen (checking first), bounded.
    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        if (!done) checkVal("done_timeout", 0, 1);
    endtask

    task automatic runDiv(input int a, input int b, input int eq, input int er, input int edz);
        int lat;
        A = 4'(a);
        B = 4'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        A = 4'(~a);
        B = 4'(b + 7);
        waitDone(lat);
        checkVal($sformatf("lat_%0d_%0d", a, b), lat, (b == 0) ? 0 : 4);
        checkVal($sformatf("q_%0d_%0d", a, b), Q, eq);
        checkVal($sformatf("r_%0d_%0d", a, b), R, er);
        checkVal($sformatf("dz_%0d_%0d", a, b), div_zero, edz);
        tick();
        checkVal($sformatf("busy_after_%0d_%0d", a, b), busy, 0);
        checkVal($sformatf("done_after_%0d_%0d", a, b), done, 0);
    endtask

    task automatic countDone(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) pulses++;
        end
    endtask

    initial begin
        int n;
        int pulses;
        int ea, eb, eq, er, edz;
        rst_n = 1'b0;
        start = 1'b1;
        A = 4'd5;
        B = 4'd1;
        tick();
        tick();
        checkVal("rst_q", Q, 0);
        checkVal("rst_r", R, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_dz", div_zero, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        checkVal("idle_busy", busy, 0);

        // 13 / 3 with cycle-accurate checks
        A = 4'd13;
        B = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = 4'd2;
        B = 4'd7;
        checkVal("d13_busy_k", busy, 1);
        checkVal("d13_done_k", done, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkVal($sformatf("d13_done_k%0d", i), done, 0);
            checkVal($sformatf("d13_busy_k%0d", i), busy, 1);
        end
        tick();
        checkVal("d13_done_k4", done, 1);
        checkVal("d13_q", Q, 4);
        checkVal("d13_r", R, 1);
        checkVal("d13_dz", div_zero, 0);
        checkVal("d13_busy_k4", busy, 1);
        tick();
        checkVal("d13_done_k5", done, 0);
        checkVal("d13_busy_k5", busy, 0);
        checkVal("d13_q_hold", Q, 4);
        checkVal("d13_r_hold", R, 1);

        // 7 / 0
        A = 4'd7;
        B = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkVal("d7z_done", done, 1);
        checkVal("d7z_q", Q, 15);
        checkVal("d7z_r", R, 7);
        checkVal("d7z_dz", div_zero, 1);
        checkVal("d7z_busy", busy, 1);
        tick();
        checkVal("d7z_busy_next", busy, 0);
        checkVal("d7z_done_next", done, 0);
        checkVal("d7z_dz_hold", div_zero, 1);

        // Boundaries
        runDiv(15, 1, 15, 0, 0);
        runDiv(2, 9, 0, 2, 0);
        runDiv(0, 5, 0, 0, 0);
        runDiv(15, 15, 1, 0, 0);

        // Second start during CALC is ignored
        A = 4'd9;
        B = 4'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        A = 4'd1;
        B = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = 4'd15;
        B = 4'd2;
        waitDone(n);
        checkVal("ign_lat", n, 2);
        checkVal("ign_q", Q, 2);
        checkVal("ign_r", R, 1);
        countDone(8, pulses);
        checkVal("ign_extra_done", pulses, 0);

        // Reset mid-CALC with start asserted alongside reset
        A = 4'd13;
        B = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        start = 1'b1;
        A = 4'd6;
        B = 4'd2;
        tick();
        checkVal("abort_q", Q, 0);
        checkVal("abort_r", R, 0);
        checkVal("abort_busy", busy, 0);
        checkVal("abort_done", done, 0);
        checkVal("abort_dz", div_zero, 0);
        rst_n = 1'b1;
        start = 1'b0;
        countDone(8, pulses);
        checkVal("abort_no_done", pulses, 0);
        runDiv(6, 2, 3, 0, 0);

        // Exhaustive sweep with start held high
        A = 4'd0;
        B = 4'd0;
        start = 1'b1;
        for (int idx = 0; idx < 256; idx++) begin
            ea = idx / 16;
            eb = idx % 16;
            if (idx == 0) begin
                waitDone(n);
                if (done) n = n + 1;
            end else begin
                tick();
                waitDone(n);
                n = n + 1;
                checkVal($sformatf("sw_gap_%0d_%0d", ea, eb), n, (eb == 0) ? 2 : 6);
            end
            if (eb == 0) begin
                eq = 15;
                er = ea;
                edz = 1;
            end else begin
                eq = ea / eb;
                er = ea % eb;
                edz = 0;
            end
            checkVal($sformatf("sw_q_%0d_%0d", ea, eb), Q, eq);
            checkVal($sformatf("sw_r_%0d_%0d", ea, eb), R, er);
            checkVal($sformatf("sw_dz_%0d_%0d", ea, eb), div_zero, edz);
            if (idx < 255) begin
                A = 4'((idx + 1) / 16);
                B = 4'((idx + 1) % 16);
            end else begin
                start = 1'b0;
            end
        end
        tick();
        tick();
        checkVal("final_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
